// File: rtl/phase_timer_if.sv
// Bundles the phase_timer control, configuration and display signals.
// Optional pause input is present only when PHASE_TIMER_PAUSE_EN is defined.
interface phase_timer_if #(
    parameter int NUM_PHASES = 6,
    parameter int PHASE_W    = 3
);
    logic                  tick;
    logic [PHASE_W-1:0]    phase;
    logic                  down_mode;
    logic                  cfg_we;
    logic [PHASE_W-1:0]    cfg_idx;
    logic [15:0]           cfg_dur;
    logic                  cfg_err;
    logic                  done;
    logic [NUM_PHASES-1:0] done_vec;
    logic [3:0]            seg3;
    logic [3:0]            seg2;
    logic [3:0]            seg1;
    logic [3:0]            seg0;
`ifdef PHASE_TIMER_PAUSE_EN
    logic                  pause;
`endif

    modport master (
        output tick, phase, down_mode, cfg_we, cfg_idx, cfg_dur,
`ifdef PHASE_TIMER_PAUSE_EN
        output pause,
`endif
        input  cfg_err, done, done_vec, seg3, seg2, seg1, seg0
    );

    modport slave (
        input  tick, phase, down_mode, cfg_we, cfg_idx, cfg_dur,
`ifdef PHASE_TIMER_PAUSE_EN
        input  pause,
`endif
        output cfg_err, done, done_vec, seg3, seg2, seg1, seg0
    );
endinterface

// File: rtl/phase_timer.sv
// Per-phase BCD elapsed/remaining timer with a programmable duration table.
// Define PHASE_TIMER_PAUSE_EN to add a pause input that freezes counting.
module phase_timer #(
    parameter int NUM_PHASES = 6,
    parameter int PHASE_W    = 3
) (
    input  logic          clk,
    input  logic          reset,
    phase_timer_if.slave  pt
);

    // Digit moduli, least significant first: 0.1 s, s, 10 s, min.
    function automatic int digit_mod(input int i);
        return (i == 2) ? 6 : 10;
    endfunction

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                if (r[i*4 +: 4] == 4'(digit_mod(i) - 1)) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Saturates at zero if b exceeds a (duration rewritten below a frozen value).
    function automatic logic [15:0] bcd_sub(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] r;
        int          d;
        int          brw;
        r   = '0;
        brw = 0;
        for (int i = 0; i < 4; i++) begin
            d = int'(a[i*4 +: 4]) - int'(b[i*4 +: 4]) - brw;
            if (d < 0) begin
                d   = d + digit_mod(i);
                brw = 1;
            end else begin
                brw = 0;
            end
            r[i*4 +: 4] = 4'(d);
        end
        return (brw != 0) ? 16'h0000 : r;
    endfunction

    logic [15:0]        dur_q [NUM_PHASES];
    logic [PHASE_W-1:0] phase_q;
    logic [15:0]        elapsed_q, elapsed_d;
    logic               done_q, done_d;
    logic               cfg_err_q;

    logic               phase_ok;
    logic               timed;
    logic               pause_act;
    logic               cfg_legal;
    logic [15:0]        dur_cur;
    logic [15:0]        elapsed_inc;
    logic [15:0]        remain;
    logic [15:0]        seg_w;

`ifdef PHASE_TIMER_PAUSE_EN
    assign pause_act = pt.pause;
`else
    assign pause_act = 1'b0;
`endif

    assign phase_ok    = 32'(phase_q) < NUM_PHASES;
    assign dur_cur     = phase_ok ? dur_q[phase_q] : 16'h0000;
    assign timed       = (dur_cur != 16'h0000);
    assign elapsed_inc = bcd_inc(elapsed_q);
    assign remain      = bcd_sub(dur_cur, elapsed_q);

    assign cfg_legal = (32'(pt.cfg_idx) < NUM_PHASES)
                       && (pt.cfg_dur[15:12] <= 4'd9) && (pt.cfg_dur[11:8] <= 4'd5)
                       && (pt.cfg_dur[7:4]   <= 4'd9) && (pt.cfg_dur[3:0]  <= 4'd9);

    always_comb begin
        elapsed_d = elapsed_q;
        done_d    = done_q;
        if (pt.phase != phase_q) begin
            elapsed_d = '0;
            done_d    = 1'b0;
        end else if (!timed) begin
            elapsed_d = '0;
            done_d    = 1'b0;
        end else if (pt.tick && !done_q && !pause_act) begin
            // elapsed_q compare catches a rewrite below a value at the 9:59.9 wrap point.
            if ((elapsed_q >= dur_cur) || (elapsed_inc >= dur_cur)) begin
                elapsed_d = dur_cur;
                done_d    = 1'b1;
            end else begin
                elapsed_d = elapsed_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_q   <= '0;
            elapsed_q <= '0;
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
            for (int i = 0; i < NUM_PHASES; i++) begin
                dur_q[i] <= '0;
            end
        end else begin
            phase_q   <= pt.phase;
            elapsed_q <= elapsed_d;
            done_q    <= done_d;
            cfg_err_q <= pt.cfg_we && !cfg_legal;
            if (pt.cfg_we && cfg_legal) begin
                dur_q[pt.cfg_idx] <= pt.cfg_dur;
            end
        end
    end

    always_comb begin
        if (pt.down_mode) begin
            seg_w = timed ? remain : 16'h0000;
        end else begin
            seg_w = elapsed_q;
        end
    end

    assign pt.seg3    = seg_w[15:12];
    assign pt.seg2    = seg_w[11:8];
    assign pt.seg1    = seg_w[7:4];
    assign pt.seg0    = seg_w[3:0];
    assign pt.done    = done_q;
    assign pt.cfg_err = cfg_err_q;

    always_comb begin
        pt.done_vec = '0;
        for (int i = 0; i < NUM_PHASES; i++) begin
            pt.done_vec[i] = done_q && phase_ok && (32'(phase_q) == i);
        end
    end

endmodule

// File: tb/tb_phase_timer.sv
// Randomized bench for phase_timer against a tenths-of-a-second reference model.
module tb_phase_timer;
    localparam int NP = 6;
    localparam int PW = 3;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic pause_v = 1'b0;

    phase_timer_if #(.NUM_PHASES(NP), .PHASE_W(PW)) pt ();

    phase_timer #(.NUM_PHASES(NP), .PHASE_W(PW)) dut (
        .clk   (clk),
        .reset (reset),
        .pt    (pt)
    );

`ifdef PHASE_TIMER_PAUSE_EN
    assign pt.pause = pause_v;
`endif

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference state: durations and elapsed time as plain tenths of a second.
    int m_dur [NP];
    int m_phase;
    int m_el;
    bit m_done;
    bit m_err;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int t);
        return {4'(t / 600), 4'((t % 600) / 100), 4'((t % 100) / 10), 4'(t % 10)};
    endfunction

    function automatic int cur_dur();
        return (m_phase < NP) ? m_dur[m_phase] : 0;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NP; i++) m_dur[i] = 0;
        m_phase = 0;
        m_el    = 0;
        m_done  = 0;
        m_err   = 0;
    endtask

    task automatic model_edge();
        int cur;
        int d3, d2, d1, d0;
        bit legal;
        cur = cur_dur();
        if (int'(pt.phase) != m_phase) begin
            m_phase = int'(pt.phase);
            m_el    = 0;
            m_done  = 0;
        end else if (cur == 0) begin
            m_el   = 0;
            m_done = 0;
        end else if (pt.tick && !m_done && !pause_v) begin
            if (m_el + 1 >= cur) begin
                m_el   = cur;
                m_done = 1;
            end else begin
                m_el = m_el + 1;
            end
        end
        d3 = int'(pt.cfg_dur[15:12]);
        d2 = int'(pt.cfg_dur[11:8]);
        d1 = int'(pt.cfg_dur[7:4]);
        d0 = int'(pt.cfg_dur[3:0]);
        legal = (int'(pt.cfg_idx) < NP) && d3 <= 9 && d2 <= 5 && d1 <= 9 && d0 <= 9;
        m_err = pt.cfg_we && !legal;
        if (pt.cfg_we && legal) m_dur[int'(pt.cfg_idx)] = d3 * 600 + d2 * 100 + d1 * 10 + d0;
    endtask

    task automatic check_outputs();
        int          cur;
        logic [15:0] exp_seg;
        logic [5:0]  exp_vec;
        cur = cur_dur();
        if (pt.down_mode) exp_seg = (cur == 0) ? 16'h0 : to_bcd((cur > m_el) ? cur - m_el : 0);
        else              exp_seg = to_bcd(m_el);
        exp_vec = (m_done && m_phase < NP) ? 6'(1 << m_phase) : 6'b0;
        check_val("seg",      32'({pt.seg3, pt.seg2, pt.seg1, pt.seg0}), 32'(exp_seg));
        check_val("done",     32'(pt.done), 32'(m_done));
        check_val("done_vec", 32'(pt.done_vec), 32'(exp_vec));
        check_val("cfg_err",  32'(pt.cfg_err), 32'(m_err));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic write_cfg(input int idx, input logic [15:0] dur);
        pt.cfg_we  = 1'b1;
        pt.cfg_idx = PW'(idx);
        pt.cfg_dur = dur;
        cycle();
        pt.cfg_we  = 1'b0;
    endtask

    task automatic set_phase(input int p);
        pt.phase = PW'(p);
        cycle();
    endtask

    task automatic ticks(input int n);
        pt.tick = 1'b1;
        repeat (n) cycle();
        pt.tick = 1'b0;
    endtask

    function automatic logic [15:0] seg_now();
        return {pt.seg3, pt.seg2, pt.seg1, pt.seg0};
    endfunction

    initial begin
        pt.tick = 0; pt.phase = '0; pt.down_mode = 0;
        pt.cfg_we = 0; pt.cfg_idx = '0; pt.cfg_dur = '0;
        model_clear();
        #1;
        check_outputs();
        @(negedge clk);
        reset = 1'b1;

        // 1:00.0 duration reached after 600 ticks, then saturates
        write_cfg(2, 16'h1000);
        set_phase(2);
        ticks(599);
        check_val("r030_pre_done", 32'(pt.done), 32'd0);
        ticks(1);
        check_val("r030_seg",  32'(seg_now()), 32'h1000);
        check_val("r030_done", 32'(pt.done), 32'd1);
        check_val("r030_vec",  32'(pt.done_vec), 32'b000100);
        ticks(10);
        check_val("r030_hold", 32'(seg_now()), 32'h1000);

        // 30 s duration, 15 s elapsed, remaining display; then untimed phase
        write_cfg(3, 16'h0300);
        set_phase(3);
        ticks(150);
        pt.down_mode = 1'b1;
        #1;
        check_val("r031_remain", 32'(seg_now()), 32'h0150);
        set_phase(4);
        check_val("r031_untimed", 32'(seg_now()), 32'h0000);
        check_val("r031_done",    32'(pt.done), 32'd0);
        pt.down_mode = 1'b0;

        // rejected writes pulse cfg_err for one cycle and leave the table alone
        write_cfg(0, 16'h0600);
        check_val("r032_err_dig", 32'(pt.cfg_err), 32'd1);
        cycle();
        check_val("r032_err_low", 32'(pt.cfg_err), 32'd0);
        write_cfg(7, 16'h0100);
        check_val("r032_err_idx", 32'(pt.cfg_err), 32'd1);
        set_phase(0);
        ticks(5);
        check_val("r032_untimed", 32'(seg_now()), 32'h0000);

        // duration rewritten below elapsed: next tick saturates
        write_cfg(1, 16'h0100);
        set_phase(1);
        ticks(80);
        check_val("r033_el", 32'(seg_now()), 32'h0080);
        write_cfg(1, 16'h0050);
        ticks(1);
        check_val("r033_seg",  32'(seg_now()), 32'h0050);
        check_val("r033_done", 32'(pt.done), 32'd1);

        // minute carry, then asynchronous reset mid-count
        write_cfg(5, 16'h2000);
        set_phase(5);
        ticks(599);
        check_val("r034_599", 32'(seg_now()), 32'h0599);
        ticks(1);
        check_val("r034_carry", 32'(seg_now()), 32'h1000);
        ticks(7);
        reset = 1'b0;
        model_clear();
        #1;
        check_val("r034_rst_seg",  32'(seg_now()), 32'h0000);
        check_val("r034_rst_done", 32'(pt.done), 32'd0);
        check_outputs();
        @(negedge clk);
        reset = 1'b1;
        ticks(3);
        check_val("r034_post_rst", 32'(seg_now()), 32'h0000);

`ifdef PHASE_TIMER_PAUSE_EN
        write_cfg(2, 16'h0100);
        set_phase(2);
        ticks(20);
        pause_v = 1'b1;
        ticks(20);
        check_val("pause_hold", 32'(seg_now()), 32'h0020);
        pause_v = 1'b0;
        ticks(3);
        check_val("pause_resume", 32'(seg_now()), 32'h0023);
`endif

        repeat (4000) begin
            pt.tick      = ($urandom_range(0, 1) == 1);
            pt.down_mode = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 199) == 0) pt.phase = PW'($urandom_range(0, 7));
            pt.cfg_we = ($urandom_range(0, 29) == 0);
            if (pt.cfg_we) begin
                int d3, d2, d1, d0;
                d3 = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 15)) : 0;
                d2 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : 0;
                d1 = int'($urandom_range(0, 10));
                d0 = int'($urandom_range(0, 9));
                pt.cfg_idx = PW'($urandom_range(0, 7));
                pt.cfg_dur = {4'(d3), 4'(d2), 4'(d1), 4'(d0)};
            end
`ifdef PHASE_TIMER_PAUSE_EN
            pause_v = ($urandom_range(0, 7) == 0);
`endif
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
